// File: rtl/led_step_sequencer.sv
// Timed LED pattern sequencer: plays a small table of {mask, duration} steps
// on three LEDs, once or looping, with a global 15-level PWM brightness.
module led_step_sequencer #(
  parameter int CLK_DIV = 48000,
  parameter int DEPTH   = 8,
  parameter int DUR_W   = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int PW     = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [2:0]       cfg_mask,
  input  logic [DUR_W-1:0] cfg_dur,
  input  logic [AW-1:0]    last_step,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       brightness,
  output logic             busy,
  output logic [AW-1:0]    step_idx,
  output logic             done,
  output logic             LED0,
  output logic             LED1,
  output logic             LED2
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    step_q, step_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [2:0]       amask_q, amask_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             done_q, done_d;
  logic [3:0]       pwm_q;
  logic [2:0]       led_q;

  logic [2:0]       mask_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem  [DEPTH];

  logic             tick;
  logic             final_step;
  logic             load;
  logic [AW-1:0]    load_idx;

  // NOTE: the table is explicitly cleared on reset, so it must stay in flops
  // rather than map to a RAM macro without a reset port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mask_mem[i] <= '0;
        dur_mem[i]  <= '0;
      end
    end else if (cfg_we) begin
      mask_mem[cfg_addr] <= cfg_mask;
      dur_mem[cfg_addr]  <= cfg_dur;
    end
  end

  assign tick = (pre_q == PW'(CLK_DIV - 1));
  // A run pushed past last_step keeps going and treats the table end as final.
  assign final_step = (step_q == last_step) || (step_q == AW'(DEPTH - 1));

  // NOTE: every variable gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    rem_d    = rem_q;
    amask_d  = amask_q;
    pre_d    = pre_q;
    done_d   = 1'b0;
    load     = 1'b0;
    load_idx = '0;

    unique case (state_q)
      IDLE: begin
        amask_d = '0;
        pre_d   = '0;
        if (start && !stop) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          step_d  = '0;
          amask_d = '0;
          pre_d   = '0;
        end else begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            if (rem_q > DUR_W'(1)) begin
              rem_d = rem_q - 1'b1;
            end else if (!final_step) begin
              load     = 1'b1;
              load_idx = step_q + 1'b1;
            end else if (loop_en) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              step_d  = '0;
              amask_d = '0;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Step entry latches the table row, so later writes only affect re-entry.
    if (load) begin
      step_d  = load_idx;
      rem_d   = (dur_mem[load_idx] == '0) ? DUR_W'(1) : dur_mem[load_idx];
      amask_d = mask_mem[load_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      rem_q   <= DUR_W'(1);
      amask_q <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
      pwm_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      amask_q <= amask_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
      pwm_q   <= (pwm_q == 4'd14) ? 4'd0 : pwm_q + 4'd1;
      led_q   <= amask_q & {3{pwm_q < brightness}};
    end
  end

  assign busy     = (state_q == RUN);
  assign step_idx = step_q;
  assign done     = done_q;
  assign LED0     = led_q[0];
  assign LED1     = led_q[1];
  assign LED2     = led_q[2];

endmodule

// File: tb/tb_led_step_sequencer.sv
// Directed bench for led_step_sequencer with CLK_DIV=4, DEPTH=8, DUR_W=16.
module tb_led_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [2:0]  cfg_mask;
  logic [15:0] cfg_dur;
  logic [2:0]  last_step;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic [3:0]  brightness;
  logic        busy;
  logic [2:0]  step_idx;
  logic        done;
  logic        LED0, LED1, LED2;
  logic [2:0]  leds;

  int checks = 0;
  int failures = 0;
  int k = 0;
  int cnt_a, cnt_b, done_cnt, done_at;

  led_step_sequencer #(.CLK_DIV(4), .DEPTH(8), .DUR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mask(cfg_mask), .cfg_dur(cfg_dur), .last_step(last_step),
    .loop_en(loop_en), .start(start), .stop(stop), .brightness(brightness),
    .busy(busy), .step_idx(step_idx), .done(done),
    .LED0(LED0), .LED1(LED1), .LED2(LED2)
  );

  assign leds = {LED2, LED1, LED0};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic wait_to(input int target);
    while (k < target) tick();
  endtask

  task automatic write_step(input logic [2:0] a, input logic [2:0] m, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_mask = m; cfg_dur = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // k = 0 is the sample just after the edge that accepts start.
  task automatic start_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
  endtask

  task automatic stop_seq();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_mask = '0; cfg_dur = '0;
    last_step = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0; brightness = 4'd15;
    tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_step", step_idx, 0);
    check("reset_done", done, 0);
    check("reset_leds", leds, 0);
    rst_n = 1'b1;
    tick();

    // One-shot two-step sequence.
    write_step(3'd0, 3'b101, 16'd2);
    write_step(3'd1, 3'b010, 16'd3);
    last_step = 3'd1; loop_en = 1'b0;
    start_seq();
    check("t1_busy_start", busy, 1);
    cnt_a = 0; cnt_b = 0; done_cnt = 0; done_at = -1;
    while (k < 30) begin
      if (LED0 && LED2) cnt_a++;
      if (LED1) cnt_b++;
      if (done) begin done_cnt++; done_at = k; end
      if (k == 1)  check("t1_leds_k1", leds, 3'b101);
      if (k == 9)  check("t1_leds_k9", leds, 3'b010);
      if (k == 21) check("t1_leds_k21", leds, 3'b000);
      tick();
    end
    check("t1_led02_cycles", cnt_a, 8);
    check("t1_led1_cycles", cnt_b, 12);
    check("t1_done_count", done_cnt, 1);
    check("t1_done_at", done_at, 20);
    check("t1_busy_end", busy, 0);

    // Looping: period 20 cycles, then stop in step 1.
    loop_en = 1'b1;
    start_seq();
    done_cnt = 0;
    while (k < 33) begin
      if (done) done_cnt++;
      if (k == 7)  check("t2_step_k7", step_idx, 0);
      if (k == 8)  check("t2_step_k8", step_idx, 1);
      if (k == 20) check("t2_step_k20", step_idx, 0);
      if (k == 28) check("t2_step_k28", step_idx, 1);
      if (k == 31) check("t2_busy_after_stop", busy, 0);
      if (k == 32) check("t2_leds_after_stop", leds, 0);
      if (k == 30) begin
        stop = 1'b1; tick(); stop = 1'b0;
      end else begin
        tick();
      end
    end
    check("t2_no_done", done_cnt, 0);

    // dur=0 behaves as one tick.
    write_step(3'd0, 3'b111, 16'd0);
    last_step = 3'd0; loop_en = 1'b0;
    start_seq();
    cnt_a = 0; done_at = -1;
    while (k < 12) begin
      if (leds == 3'b111) cnt_a++;
      if (done) done_at = k;
      tick();
    end
    check("t3_led_cycles", cnt_a, 4);
    check("t3_done_at", done_at, 4);

    // PWM duty with a long single looping step.
    write_step(3'd0, 3'b001, 16'd100);
    loop_en = 1'b1;
    brightness = 4'd5;
    start_seq();
    wait_to(3);
    cnt_a = 0;
    repeat (15) begin if (LED0) cnt_a++; tick(); end
    check("t4_pwm_b5", cnt_a, 5);
    cnt_a = 0;
    repeat (15) begin if (LED0) cnt_a++; tick(); end
    check("t4_pwm_b5_again", cnt_a, 5);
    brightness = 4'd0; tick(); tick();
    cnt_a = 0;
    repeat (15) begin if (LED0) cnt_a++; tick(); end
    check("t4_pwm_b0", cnt_a, 0);
    brightness = 4'd15; tick(); tick();
    cnt_a = 0;
    repeat (15) begin if (LED0) cnt_a++; tick(); end
    check("t4_pwm_b15", cnt_a, 15);
    stop_seq();
    check("t4_stopped", busy, 0);

    // Command priority and reset mid-run.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("t5_start_stop_idle", busy, 0);
    write_step(3'd0, 3'b101, 16'd2);
    write_step(3'd1, 3'b010, 16'd3);
    last_step = 3'd1; loop_en = 1'b1;
    start_seq();
    wait_to(10);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_start_in_run_step", step_idx, 1);
    check("t5_start_in_run_busy", busy, 1);
    wait_to(14);
    rst_n = 1'b0; tick();
    check("t5_rst_busy", busy, 0);
    check("t5_rst_step", step_idx, 0);
    check("t5_rst_leds", leds, 0);
    rst_n = 1'b1; tick();
    // Cleared table: step 0 is mask 0, dur 0 -> dark for one tick then done.
    last_step = 3'd0; loop_en = 1'b0;
    start_seq();
    cnt_a = 0; done_at = -1;
    while (k < 10) begin
      if (leds != 3'b000) cnt_a++;
      if (done) done_at = k;
      tick();
    end
    check("t5_table_cleared_leds", cnt_a, 0);
    check("t5_table_cleared_done", done_at, 4);

    // last_step lowered below the playing step: run to DEPTH-1 then end.
    last_step = 3'd3; loop_en = 1'b0;
    start_seq();
    done_at = -1;
    while (k < 40) begin
      if (k == 9) last_step = 3'd1;
      if (k == 31) check("t7_step_k31", step_idx, 7);
      if (done) done_at = k;
      tick();
    end
    check("t7_done_at", done_at, 32);

    // Rewriting the playing step only affects its next entry.
    write_step(3'd0, 3'b001, 16'd4);
    write_step(3'd1, 3'b010, 16'd1);
    last_step = 3'd1; loop_en = 1'b1;
    start_seq();
    wait_to(2);
    write_step(3'd0, 3'b001, 16'd1);
    while (k < 26) begin
      if (k == 15) check("t6_step_k15", step_idx, 0);
      if (k == 16) check("t6_step_k16", step_idx, 1);
      if (k == 20) check("t6_step_k20", step_idx, 0);
      if (k == 23) check("t6_step_k23", step_idx, 0);
      if (k == 24) check("t6_step_k24", step_idx, 1);
      tick();
    end
    stop_seq();
    check("t6_stopped", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
